maxpool_2x2_stream: RTL

- Downstream compute stage released by the global sequencing controller. Consumes the convolution result stream and produces the pooled feature map for the display stage.
- Performs 2x2, stride-2 max pooling on an unsigned pixel stream arriving in raster order, IMG_W x IMG_H pixels per frame.
- Uses a half-width line buffer of partial maxima, so no frame storage is needed.
- `hold` is driven by the controller's per-stage hold output (rst_2b2). While hold is high, the block stays idle and cleared.

---
 rtl/maxpool_2x2_stream.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/maxpool_2x2_stream.sv
// 2x2 stride-2 max pooling over a raster-order unsigned pixel stream.
// Ports: clk; rst (async, active-low); hold (sync idle/clear);
//   in_valid/in_data (pixel in); out_valid/out_data (pooled pixel);
//   busy (frame in progress); done (all pooled pixels emitted).
module maxpool_2x2_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int HW    = IMG_W / 2;
    localparam int BW    = (HW > 1) ? $clog2(HW) : 1;
    localparam int TOTAL = HW * (IMG_H / 2);
    localparam int OW    = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic [OW-1:0]       out_cnt_q, out_cnt_d;
    logic [DATA_W-1:0]   pair_q, pair_d;
    logic [DATA_W-1:0]   lbuf_q [HW];
    logic [DATA_W-1:0]   lbuf_d [HW];
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;

    logic [BW-1:0]       bidx;
    logic [DATA_W-1:0]   pair_max;
    logic [DATA_W-1:0]   top_max;
    logic [DATA_W-1:0]   win_max;

    // Window datapath: the line buffer slot holds the top-row pair max
    // for the window that the current odd column closes.
    always_comb begin
        bidx     = BW'(col_q >> 1);
        pair_max = (in_data > pair_q) ? in_data : pair_q;
        top_max  = lbuf_q[bidx];
        win_max  = (top_max > pair_max) ? top_max : pair_max;
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        out_cnt_d   = out_cnt_q;
        pair_d      = pair_q;
        lbuf_d      = lbuf_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (in_valid) begin
                    if (col_q == CW'(IMG_W - 1)) begin
                        col_d = '0;
                        row_d = (row_q == RW'(IMG_H - 1)) ? '0
                                                           : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end

                    if (!col_q[0]) begin
                        pair_d = in_data;
                    end else if (!row_q[0]) begin
                        lbuf_d[bidx] = pair_max;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = win_max;
                        out_cnt_d   = out_cnt_q + 1'b1;
                        if (out_cnt_q == OW'(TOTAL - 1)) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // hold wins over everything, discarding any partial frame.
        if (hold) begin
            state_d     = S_IDLE;
            col_d       = '0;
            row_d       = '0;
            out_cnt_d   = '0;
            pair_d      = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            for (int i = 0; i < HW; i++) begin
                lbuf_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            out_cnt_q   <= '0;
            pair_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < HW; i++) begin
                lbuf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            out_cnt_q   <= out_cnt_d;
            pair_q      <= pair_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            lbuf_q      <= lbuf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);

endmodule
